// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared opcode encoding, FSM state type and helpers for the
// E-stage multiply/divide unit. MD_* values must stay in sync with the
// Controller and StallCtrl decode.
package md_unit_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Only these four opcodes start a timed operation.
    function automatic logic is_arith(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: E-stage <-> multiply/divide unit signal bundle.
//   Start/MDOp/A/B : request from the E stage (master drives)
//   Busy/HI/LO/MDOut : status and results from md_unit (slave drives)
interface md_unit_if;
    import md_unit_pkg::*;

    logic              Start;
    logic [3:0]        MDOp;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              Busy;
    logic [DATA_W-1:0] HI;
    logic [DATA_W-1:0] LO;
    logic [DATA_W-1:0] MDOut;

    modport master (output Start, MDOp, A, B, input Busy, HI, LO, MDOut);
    modport slave  (input Start, MDOp, A, B, output Busy, HI, LO, MDOut);

endinterface

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit beside the ALU in E. Computes the 64-bit
// result combinationally when Start is accepted, parks it in PHI/PLO, and
// commits it to the architectural HI/LO after a fixed latency while Busy
// holds md-class instructions in D.
// Ports:
//   clk   - pipeline clock
//   reset - asynchronous, active-high reset
//   md    - md_unit_if.slave: Start, MDOp, A, B in; Busy, HI, LO, MDOut out
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic     clk,
    input  logic     reset,
    md_unit_if.slave md
);

    md_state_e         state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              ld_pend, commit, wr_hi, wr_lo;

    logic [DATA_W-1:0] phi, plo, hi, lo;
    logic              pend_ok;

    // ---------------- arithmetic ----------------
    logic [63:0]       prod_s, prod_u;
    logic              a_neg, b_neg, signed_div;
    logic [DATA_W-1:0] a_mag, b_mag, dvd, dvs, quo, rem, q_fix, r_fix;
    logic [63:0]       res;
    logic              res_ok;

    // Low 64 bits of the sign-extended product equal the signed product.
    assign prod_s = {{32{md.A[31]}}, md.A} * {{32{md.B[31]}}, md.B};
    assign prod_u = {32'd0, md.A} * {32'd0, md.B};

    // One shared unsigned divider; signed division works on magnitudes and
    // fixes signs afterwards. This also makes 0x80000000 / -1 come out as
    // 0x80000000 rem 0 without relying on signed-overflow behaviour.
    assign signed_div = (md.MDOp == MD_DIV);
    assign a_neg      = signed_div & md.A[31];
    assign b_neg      = signed_div & md.B[31];
    assign a_mag      = a_neg ? (32'd0 - md.A) : md.A;
    assign b_mag      = b_neg ? (32'd0 - md.B) : md.B;
    assign dvd        = a_mag;
    // Divide-by-zero result is discarded anyway; avoid a zero divisor.
    assign dvs        = (b_mag == '0) ? 32'd1 : b_mag;
    assign quo        = dvd / dvs;
    assign rem        = dvd % dvs;
    assign q_fix      = (a_neg ^ b_neg) ? (32'd0 - quo) : quo;
    assign r_fix      = a_neg ? (32'd0 - rem) : rem;

    always_comb begin
        res    = '0;
        res_ok = 1'b1;
        case (md.MDOp)
            MD_MULT:  res = prod_s;
            MD_MULTU: res = prod_u;
            MD_DIV, MD_DIVU: begin
                res    = {r_fix, q_fix};
                res_ok = (md.B != '0);
            end
            default: ;
        endcase
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ld_pend   = 1'b0;
        commit    = 1'b0;
        wr_hi     = 1'b0;
        wr_lo     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (md.Start && is_arith(md.MDOp)) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = is_div(md.MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    ld_pend   = 1'b1;
                end else if (md.MDOp == MD_MTHI) begin
                    wr_hi = 1'b1;
                end else if (md.MDOp == MD_MTLO) begin
                    wr_lo = 1'b1;
                end
            end
            ST_RUN: begin
                // Start/mthi/mtlo are ignored here; the stall logic keeps them out.
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_IDLE;
                    commit    = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- result registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phi     <= '0;
            plo     <= '0;
            pend_ok <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            if (ld_pend) begin
                {phi, plo} <= res;
                pend_ok    <= res_ok;
            end
            if (commit && pend_ok) begin
                hi <= phi;
                lo <= plo;
            end
            if (wr_hi) hi <= md.A;
            if (wr_lo) lo <= md.A;
        end
    end

    assign md.Busy  = (state == ST_RUN);
    assign md.HI    = hi;
    assign md.LO    = lo;
    // Reads only committed values; PHI/PLO never leak out.
    assign md.MDOut = (md.MDOp == MD_MFHI) ? hi :
                      (md.MDOp == MD_MFLO) ? lo : '0;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
    import md_unit_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    md_unit_if md();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk  (clk),
        .reset(reset),
        .md   (md)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int prot_viol = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Protocol monitor: md-class requests must never reach E while Busy.
    always @(posedge clk)
        if (!reset && md.Busy === 1'b1 &&
            (md.Start === 1'b1 || md.MDOp == MD_MTHI || md.MDOp == MD_MTLO))
            prot_viol <= prot_viol + 1;

    // Pulse Start for one cycle and record the expected outcome.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int en,
                         output int s);
        exp_t e;
        @(posedge clk); #1;
        md.Start = 1'b1; md.MDOp = op; md.A = a; md.B = b;
        e.hi = ehi; e.lo = elo; e.n = en;
        exp_q.push_back(e);
        @(posedge clk); #1;
        s = cyc;
        md.Start = 1'b0; md.MDOp = MD_NONE;
    endtask

    task automatic wait_done(input int s, output int n, output bit to);
        int g = 0;
        to = 1'b0;
        while (md.Busy === 1'b1) begin
            if (g >= 200) begin to = 1'b1; break; end
            @(posedge clk); #1;
            g++;
        end
        n = cyc - s;
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] a);
        @(posedge clk); #1;
        md.MDOp = op; md.A = a;
        @(posedge clk); #1;
        md.MDOp = MD_NONE;
    endtask

    task automatic test_reset();
        int s;
        @(negedge clk);
        tests++; if (md.Busy !== 1'b0)  begin fails++; $display("FAIL reset_busy: got %b want 0", md.Busy); end
        tests++; if (md.HI !== 32'd0)   begin fails++; $display("FAIL reset_hi: got %h want 0", md.HI); end
        tests++; if (md.LO !== 32'd0)   begin fails++; $display("FAIL reset_lo: got %h want 0", md.LO); end
        reset = 1'b0;
        issue(MD_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 5, s);
        @(posedge clk); #1;
        tests++; if (md.Busy !== 1'b1)  begin fails++; $display("FAIL midrun_busy_pre: got %b want 1", md.Busy); end
        reset = 1'b1; #1;
        tests++; if (md.Busy !== 1'b0)  begin fails++; $display("FAIL midrun_busy: got %b want 0", md.Busy); end
        tests++; if (md.HI !== 32'd0 || md.LO !== 32'd0)
            begin fails++; $display("FAIL midrun_hilo: got %h/%h want 0/0", md.HI, md.LO); end
        #2; reset = 1'b0;
        repeat (12) begin @(posedge clk); #1; end
        tests++; if (md.HI !== 32'd0 || md.LO !== 32'd0 || md.Busy !== 1'b0)
            begin fails++; $display("FAIL midrun_no_commit: got %h/%h busy %b want 0/0 busy 0", md.HI, md.LO, md.Busy); end
        exp_q.delete();
    endtask

    task automatic test_mult();
        logic [3:0]  ops[2] = '{MD_MULT, MD_MULTU};
        logic [31:0] ehs[2] = '{32'hFFFF_FFFF, 32'h0000_0002};
        int s, n; bit to; exp_t e;
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], 32'hFFFF_FFFE, 32'd3, ehs[i], 32'hFFFF_FFFA, 5, s);
            wait_done(s, n, to);
            e = exp_q.pop_front();
            tests++; if (to || n != e.n) begin fails++; $display("FAIL mult%0d_busy: got %0d cycles want %0d", i, n, e.n); end
            tests++; if (md.HI !== e.hi) begin fails++; $display("FAIL mult%0d_hi: got %h want %h", i, md.HI, e.hi); end
            tests++; if (md.LO !== e.lo) begin fails++; $display("FAIL mult%0d_lo: got %h want %h", i, md.LO, e.lo); end
        end
    endtask

    task automatic test_div();
        logic [3:0]  ops[3] = '{MD_DIV, MD_DIVU, MD_DIV};
        logic [31:0] as[3]  = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
        logic [31:0] bs[3]  = '{32'd2, 32'd2, 32'hFFFF_FFFF};
        logic [31:0] ehs[3] = '{32'hFFFF_FFFF, 32'd1, 32'd0};
        logic [31:0] els[3] = '{32'hFFFF_FFFD, 32'd3, 32'h8000_0000};
        int s, n; bit to; exp_t e;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], as[i], bs[i], ehs[i], els[i], 10, s);
            wait_done(s, n, to);
            e = exp_q.pop_front();
            tests++; if (to || n != e.n) begin fails++; $display("FAIL div%0d_busy: got %0d cycles want %0d", i, n, e.n); end
            tests++; if (md.HI !== e.hi) begin fails++; $display("FAIL div%0d_hi: got %h want %h", i, md.HI, e.hi); end
            tests++; if (md.LO !== e.lo) begin fails++; $display("FAIL div%0d_lo: got %h want %h", i, md.LO, e.lo); end
        end
    endtask

    task automatic test_div_zero();
        int s, n; bit to; exp_t e;
        mt(MD_MTHI, 32'h11);
        mt(MD_MTLO, 32'h22);
        tests++; if (md.HI !== 32'h11 || md.LO !== 32'h22)
            begin fails++; $display("FAIL mt_setup: got %h/%h want 11/22", md.HI, md.LO); end
        issue(MD_DIVU, 32'd5, 32'd0, 32'h11, 32'h22, 10, s);
        wait_done(s, n, to);
        e = exp_q.pop_front();
        tests++; if (to || n != e.n) begin fails++; $display("FAIL divz_busy: got %0d cycles want %0d", n, e.n); end
        tests++; if (md.HI !== e.hi || md.LO !== e.lo)
            begin fails++; $display("FAIL divz_hilo: got %h/%h want %h/%h", md.HI, md.LO, e.hi, e.lo); end
    endtask

    task automatic test_mt_mf();
        @(posedge clk); #1;
        md.MDOp = MD_MTHI; md.A = 32'hDEAD_BEEF;
        tests++; if (md.Busy !== 1'b0) begin fails++; $display("FAIL mthi_busy0: got %b want 0", md.Busy); end
        @(posedge clk); #1;
        md.MDOp = MD_NONE;
        tests++; if (md.HI !== 32'hDEAD_BEEF) begin fails++; $display("FAIL mthi_hi: got %h want deadbeef", md.HI); end
        tests++; if (md.Busy !== 1'b0) begin fails++; $display("FAIL mthi_busy1: got %b want 0", md.Busy); end
        md.MDOp = MD_MFHI; #1;
        tests++; if (md.MDOut !== 32'hDEAD_BEEF) begin fails++; $display("FAIL mfhi: got %h want deadbeef", md.MDOut); end
        md.MDOp = MD_MFLO; #1;
        tests++; if (md.MDOut !== 32'h22) begin fails++; $display("FAIL mflo: got %h want 22", md.MDOut); end
        md.MDOp = MD_NONE; #1;
        tests++; if (md.MDOut !== 32'd0) begin fails++; $display("FAIL mdout_none: got %h want 0", md.MDOut); end
        mt(MD_MTLO, 32'h1234_5678);
        tests++; if (md.LO !== 32'h1234_5678 || md.HI !== 32'hDEAD_BEEF)
            begin fails++; $display("FAIL mtlo: got %h/%h want deadbeef/12345678", md.HI, md.LO); end
    endtask

    task automatic test_start_during_busy();
        int s, n, v0; bit to; exp_t e;
        v0 = prot_viol;
        issue(MD_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 10, s);
        @(posedge clk); #1;
        md.MDOp = MD_MFLO; #1;
        tests++; if (md.MDOut !== 32'h1234_5678) begin fails++; $display("FAIL pend_hidden: got %h want 12345678", md.MDOut); end
        @(posedge clk); #1;
        md.Start = 1'b1; md.MDOp = MD_MULT; md.A = 32'd1; md.B = 32'd1;
        @(posedge clk); #1;
        md.Start = 1'b0; md.MDOp = MD_NONE;
        wait_done(s, n, to);
        e = exp_q.pop_front();
        tests++; if (to || n != e.n) begin fails++; $display("FAIL bb_busy: got %0d cycles want %0d", n, e.n); end
        tests++; if (md.HI !== e.hi || md.LO !== e.lo)
            begin fails++; $display("FAIL bb_hilo: got %h/%h want %h/%h", md.HI, md.LO, e.hi, e.lo); end
        tests++; if (prot_viol - v0 != 1) begin fails++; $display("FAIL bb_protocol: got %0d violations want 1", prot_viol - v0); end
        repeat (3) begin @(posedge clk); #1; end
        tests++; if (md.Busy !== 1'b0 || md.LO !== 32'd14)
            begin fails++; $display("FAIL bb_ignored: got busy %b lo %h want busy 0 lo e", md.Busy, md.LO); end
    endtask

    initial begin
        md.Start = 1'b0; md.MDOp = MD_NONE; md.A = '0; md.B = '0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_mt_mf();
        test_start_during_busy();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
